// File: rtl/cad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cad_pkg
// Brief   : Shared constants, state encoding and size/mode lookups for the
//           CAD engine top-level sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package cad_pkg;

    localparam int RES_W     = 20;
    localparam int IMG_NUM   = 16;
    localparam int KER_NUM   = 16;
    localparam int KER_ELEMS = 25;
    localparam int KER_WORDS = KER_NUM * KER_ELEMS;

    localparam logic [1:0] SIZE_8  = 2'd0;
    localparam logic [1:0] SIZE_16 = 2'd1;
    localparam logic [1:0] SIZE_32 = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_IMG = 3'd1,
        LOAD_KER = 3'd2,
        WAIT_SEL = 3'd3,
        SEL2     = 3'd4,
        RUN      = 3'd5
    } state_e;

    // The reserved encoding 3 behaves as 8x8.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        logic [1:0] r;
        r = (size == 2'd3) ? SIZE_8 : size;
        return r;
    endfunction

    function automatic logic [14:0] img_words(input logic [1:0] size);
        logic [14:0] r;
        case (size)
            SIZE_16: r = 15'(IMG_NUM * 16 * 16);
            SIZE_32: r = 15'(IMG_NUM * 32 * 32);
            default: r = 15'(IMG_NUM * 8 * 8);
        endcase
        return r;
    endfunction

    // mode 0: ((S-4)/2)^2 pooled outputs; mode 1: (S+4)^2 deconv outputs
    function automatic logic [10:0] res_count(input logic [1:0] size, input logic mode);
        logic [10:0] r;
        case (size)
            SIZE_16: r = mode ? 11'd400  : 11'd36;
            SIZE_32: r = mode ? 11'd1296 : 11'd196;
            default: r = mode ? 11'd144  : 11'd4;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cad_ser.sv
`default_nettype none
// ============================================================================
// Module  : cad_ser
// Brief   : LSB-first result serializer with a ready that allows gapless
//           back-to-back words.
// Revision: 1.0 - initial release
// ============================================================================
module cad_ser
    import cad_pkg::*;
#(
    parameter int WIDTH = RES_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             last_o,
    output logic             out_valid_o,
    output logic             out_value_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             active_q, active_d;
    logic             w_last;

    assign w_last      = active_q && (bit_cnt_q == LAST_BIT);
    assign ready_o     = !active_q || w_last;
    assign last_o      = w_last;
    assign out_valid_o = active_q;
    assign out_value_o = active_q & shift_q[0];

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        active_d  = active_q;
        // A load on the final bit replaces the word with no idle cycle.
        if (load_i) begin
            shift_d   = data_i;
            bit_cnt_d = '0;
            active_d  = 1'b1;
        end else if (w_last) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            active_d  = 1'b0;
        end else if (active_q) begin
            shift_d   = {1'b0, shift_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            active_q  <= active_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cad_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cad_ctrl
// Brief   : CAD engine sequencer: SRAM load addressing, selection capture,
//           compute launch and serial result output.
// Revision: 1.0 - initial release
// ============================================================================
module cad_ctrl
    import cad_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [1:0]   matrix_size,
    input  logic [7:0]   matrix,
    input  logic         in_valid2,
    input  logic         mode,
    input  logic [3:0]   matrix_idx,
    output logic         img_we,
    output logic [13:0]  img_addr,
    output logic         kern_we,
    output logic [8:0]   kern_addr,
    output logic [7:0]   wdata,
    output logic         start,
    output logic         op_mode,
    output logic [3:0]   img_sel,
    output logic [3:0]   ker_sel,
    output logic [1:0]   size_r,
    input  logic         res_valid,
    input  logic [19:0]  res_data,
    output logic         res_ready,
    output logic         out_valid,
    output logic         out_value,
    output logic         busy
);

    state_e      state_q, state_d;
    logic [13:0] img_cnt_q, img_cnt_d;
    logic [8:0]  ker_cnt_q, ker_cnt_d;
    logic [10:0] res_cnt_q, res_cnt_d;
    logic        img_we_q, img_we_d;
    logic [13:0] img_addr_q, img_addr_d;
    logic        kern_we_q, kern_we_d;
    logic [8:0]  kern_addr_q, kern_addr_d;
    logic [7:0]  wdata_q;
    logic        start_q, start_d;
    logic        op_mode_q, op_mode_d;
    logic [3:0]  img_sel_q, img_sel_d;
    logic [3:0]  ker_sel_q, ker_sel_d;
    logic [1:0]  size_q, size_d;

    logic        w_img_last;
    logic        w_ker_last;
    logic [10:0] w_res_target;
    logic        w_res_done;
    logic        w_res_ready;
    logic        w_accept;
    logic        w_ser_ready;
    logic        w_ser_last;
    logic        w_load_start;

    assign w_img_last   = ({1'b0, img_cnt_q} == (img_words(size_q) - 15'd1));
    assign w_ker_last   = (ker_cnt_q == 9'(KER_WORDS - 1));
    assign w_res_target = res_count(size_q, op_mode_q);
    assign w_res_done   = (res_cnt_q == w_res_target);
    assign w_res_ready  = (state_q == RUN) && w_ser_ready && !w_res_done;
    assign w_accept     = res_valid && w_res_ready;
    // A selection beat wins over a new pattern if both arrive in WAIT_SEL.
    assign w_load_start = in_valid &&
                          ((state_q == IDLE) || ((state_q == WAIT_SEL) && !in_valid2));

    always_comb begin
        state_d     = state_q;
        img_cnt_d   = img_cnt_q;
        ker_cnt_d   = ker_cnt_q;
        res_cnt_d   = res_cnt_q;
        img_we_d    = 1'b0;
        img_addr_d  = img_addr_q;
        kern_we_d   = 1'b0;
        kern_addr_d = kern_addr_q;
        start_d     = 1'b0;
        op_mode_d   = op_mode_q;
        img_sel_d   = img_sel_q;
        ker_sel_d   = ker_sel_q;
        size_d      = size_q;

        case (state_q)
            LOAD_IMG: begin
                if (in_valid) begin
                    img_we_d   = 1'b1;
                    img_addr_d = img_cnt_q;
                    if (w_img_last) begin
                        img_cnt_d = '0;
                        ker_cnt_d = '0;
                        state_d   = LOAD_KER;
                    end else begin
                        img_cnt_d = img_cnt_q + 1'b1;
                    end
                end
            end
            LOAD_KER: begin
                if (in_valid) begin
                    kern_we_d   = 1'b1;
                    kern_addr_d = ker_cnt_q;
                    if (w_ker_last) begin
                        ker_cnt_d = '0;
                        state_d   = WAIT_SEL;
                    end else begin
                        ker_cnt_d = ker_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_SEL: begin
                if (in_valid2) begin
                    op_mode_d = mode;
                    img_sel_d = matrix_idx;
                    state_d   = SEL2;
                end
            end
            SEL2: begin
                ker_sel_d = matrix_idx;
                start_d   = 1'b1;
                res_cnt_d = '0;
                state_d   = RUN;
            end
            RUN: begin
                if (w_accept) begin
                    res_cnt_d = res_cnt_q + 1'b1;
                end
                if (w_res_done && w_ser_last) begin
                    state_d = WAIT_SEL;
                end
            end
            default: ;
        endcase

        // Beat 0 of a pattern is written here; the counter then points at beat 1.
        if (w_load_start) begin
            size_d     = norm_size(matrix_size);
            img_we_d   = 1'b1;
            img_addr_d = '0;
            img_cnt_d  = 14'd1;
            ker_cnt_d  = '0;
            state_d    = LOAD_IMG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            img_cnt_q   <= '0;
            ker_cnt_q   <= '0;
            res_cnt_q   <= '0;
            img_we_q    <= 1'b0;
            img_addr_q  <= '0;
            kern_we_q   <= 1'b0;
            kern_addr_q <= '0;
            wdata_q     <= '0;
            start_q     <= 1'b0;
            op_mode_q   <= 1'b0;
            img_sel_q   <= '0;
            ker_sel_q   <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            img_cnt_q   <= img_cnt_d;
            ker_cnt_q   <= ker_cnt_d;
            res_cnt_q   <= res_cnt_d;
            img_we_q    <= img_we_d;
            img_addr_q  <= img_addr_d;
            kern_we_q   <= kern_we_d;
            kern_addr_q <= kern_addr_d;
            wdata_q     <= matrix;
            start_q     <= start_d;
            op_mode_q   <= op_mode_d;
            img_sel_q   <= img_sel_d;
            ker_sel_q   <= ker_sel_d;
            size_q      <= size_d;
        end
    end

    cad_ser #(
        .WIDTH (RES_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (w_accept),
        .data_i      (res_data),
        .ready_o     (w_ser_ready),
        .last_o      (w_ser_last),
        .out_valid_o (out_valid),
        .out_value_o (out_value)
    );

    assign img_we    = img_we_q;
    assign img_addr  = img_addr_q;
    assign kern_we   = kern_we_q;
    assign kern_addr = kern_addr_q;
    assign wdata     = wdata_q;
    assign start     = start_q;
    assign op_mode   = op_mode_q;
    assign img_sel   = img_sel_q;
    assign ker_sel   = ker_sel_q;
    assign size_r    = size_q;
    assign res_ready = w_res_ready;
    assign busy      = !((state_q == IDLE) || (state_q == WAIT_SEL));

endmodule
`default_nettype wire

// File: tb/tb_cad_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cad_ctrl
// Brief   : Directed self-checking bench for the CAD sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cad_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  matrix_size = '0;
    logic [7:0]  matrix = '0;
    logic        in_valid2 = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  matrix_idx = '0;
    logic        res_valid = 1'b0;
    logic [19:0] res_data = '0;
    logic        img_we, kern_we, start, op_mode, res_ready, out_valid, out_value, busy;
    logic [13:0] img_addr;
    logic [8:0]  kern_addr;
    logic [7:0]  wdata;
    logic [3:0]  img_sel, ker_sel;
    logic [1:0]  size_r;
    logic [48:0] all_out;

    cad_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .matrix_size (matrix_size),
        .matrix      (matrix),
        .in_valid2   (in_valid2),
        .mode        (mode),
        .matrix_idx  (matrix_idx),
        .img_we      (img_we),
        .img_addr    (img_addr),
        .kern_we     (kern_we),
        .kern_addr   (kern_addr),
        .wdata       (wdata),
        .start       (start),
        .op_mode     (op_mode),
        .img_sel     (img_sel),
        .ker_sel     (ker_sel),
        .size_r      (size_r),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .out_valid   (out_valid),
        .out_value   (out_value),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign all_out = {img_we, img_addr, kern_we, kern_addr, wdata, start, op_mode,
                      img_sel, ker_sel, size_r, res_ready, out_valid, out_value, busy};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [19:0] word;
        int          gap;
        logic [19:0] exp_word;
    } vec_t;

    vec_t cur[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [1:0] sz, input int nimg, input string tag);
        int bad_img;
        int bad_ker;
        bad_img = 0;
        bad_ker = 0;
        for (int i = 0; i < nimg + 400; i++) begin
            if (i == 300) begin
                in_valid = 1'b0;
                step();
                if (img_we !== 1'b0 || img_addr !== 14'd299) bad_img++;
            end
            in_valid    = 1'b1;
            matrix      = 8'(i * 7 + 1);
            matrix_size = (i == 0) ? sz : 2'd2;
            in_valid2   = (i == nimg + 5);
            matrix_idx  = 4'hF;
            mode        = 1'b1;
            step();
            if (i < nimg) begin
                if (img_we !== 1'b1 || kern_we !== 1'b0 || img_addr !== 14'(i) ||
                    wdata !== 8'(i * 7 + 1) || busy !== 1'b1) bad_img++;
            end else begin
                if (kern_we !== 1'b1 || img_we !== 1'b0 || kern_addr !== 9'(i - nimg) ||
                    wdata !== 8'(i * 7 + 1)) bad_ker++;
            end
        end
        in_valid    = 1'b0;
        in_valid2   = 1'b0;
        mode        = 1'b0;
        matrix      = '0;
        matrix_size = '0;
        matrix_idx  = '0;
        step();
        check({tag, "_img_seq"}, 64'(bad_img), 64'd0);
        check({tag, "_ker_seq"}, 64'(bad_ker), 64'd0);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        check({tag, "_we_idle"}, 64'({img_we, kern_we}), 64'd0);
        check({tag, "_last_img_addr"}, 64'(img_addr), 64'(nimg - 1));
    endtask

    task automatic do_sel(input logic m, input logic [3:0] img, input logic [3:0] ker);
        in_valid2  = 1'b1;
        mode       = m;
        matrix_idx = img;
        step();
        check("sel_beat1_busy", 64'(busy), 64'd1);
        check("sel_beat1_start", 64'(start), 64'd0);
        mode       = ~m;
        matrix_idx = ker;
        step();
        in_valid2  = 1'b0;
        mode       = 1'b0;
        matrix_idx = '0;
        check("sel_start", 64'(start), 64'd1);
        check("sel_latched", 64'({op_mode, img_sel, ker_sel}), 64'({m, img, ker}));
        step();
        check("sel_start_single", 64'(start), 64'd0);
    endtask

    task automatic run_results(input string tag, input int exp_zero_total, input int exp_max_run);
        int   nres, idx, gap_left, bits, zeros, run, max_run, bad, bad_idle, guard;
        logic acc;
        nres     = cur.size();
        idx      = 0;
        gap_left = cur[0].gap;
        bits     = 0;
        zeros    = 0;
        run      = 0;
        max_run  = 0;
        bad      = 0;
        bad_idle = 0;
        guard    = 0;
        while (bits < nres * 20 && guard < nres * 20 + 400) begin
            if (idx < nres) begin
                if (gap_left > 0) begin
                    res_valid = 1'b0;
                    if (res_ready) gap_left--;
                end else begin
                    res_valid = 1'b1;
                    res_data  = cur[idx].word;
                end
            end else begin
                res_valid = 1'b1;
                res_data  = 20'hDEAD0;
            end
            acc = res_valid && res_ready;
            step();
            guard++;
            if (acc && idx < nres) begin
                idx++;
                if (idx < nres) gap_left = cur[idx].gap;
            end
            if (out_valid === 1'b1) begin
                if (bits > 0 && run > 0) begin
                    zeros += run;
                    if (run > max_run) max_run = run;
                end
                run = 0;
                if (out_value !== cur[bits / 20].exp_word[bits % 20]) bad++;
                bits++;
            end else begin
                if (out_value !== 1'b0) bad_idle++;
                if (bits > 0) run++;
            end
        end
        check({tag, "_bit_count"}, 64'(bits), 64'(nres * 20));
        check({tag, "_bit_stream"}, 64'(bad), 64'd0);
        check({tag, "_idle_value"}, 64'(bad_idle), 64'd0);
        check({tag, "_gap_total"}, 64'(zeros), 64'(exp_zero_total));
        check({tag, "_gap_max"}, 64'(max_run), 64'(exp_max_run));
        step();
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_back_to_wait"}, 64'({busy, res_ready}), 64'd0);
        res_valid = 1'b0;
        res_data  = '0;
        step();
    endtask

    initial begin
        logic [19:0] w;

        repeat (3) step();
        check("reset_outputs", 64'(all_out), 64'd0);
        rst = 1'b0;
        step();

        // Selection beats in IDLE must be ignored.
        in_valid2  = 1'b1;
        mode       = 1'b1;
        matrix_idx = 4'hA;
        step();
        step();
        in_valid2  = 1'b0;
        mode       = 1'b0;
        matrix_idx = '0;
        check("idle_sel_ignored", 64'({start, op_mode, img_sel, busy}), 64'd0);
        step();
        check("idle_no_start", 64'(start), 64'd0);

        // Partial load interrupted by an asynchronous reset.
        for (int i = 0; i < 500; i++) begin
            in_valid    = 1'b1;
            matrix      = 8'(i + 3);
            matrix_size = 2'd0;
            step();
        end
        check("pre_reset_addr", 64'(img_addr), 64'd499);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_reset", 64'(all_out), 64'd0);
        in_valid = 1'b0;
        matrix   = '0;
        step();
        rst = 1'b0;
        step();

        do_load(2'd0, 1024, "load8");
        check("load8_size", 64'(size_r), 64'd0);

        // Back-to-back results must serialize with no idle cycle.
        do_sel(1'b0, 4'd2, 4'd11);
        cur.delete();
        cur.push_back('{20'h00001, 0, 20'h00001});
        cur.push_back('{20'hFFFFF, 0, 20'hFFFFF});
        cur.push_back('{20'h80000, 0, 20'h80000});
        cur.push_back('{20'h12345, 0, 20'h12345});
        run_results("gapless", 0, 0);

        // Producer withholds results for 3 ready cycles between words.
        do_sel(1'b0, 4'd6, 4'd1);
        cur.delete();
        cur.push_back('{20'hA5A5A, 0, 20'hA5A5A});
        cur.push_back('{20'h0F0F0, 3, 20'h0F0F0});
        cur.push_back('{20'h00003, 3, 20'h00003});
        cur.push_back('{20'h7FFFE, 3, 20'h7FFFE});
        run_results("stall", 9, 3);

        // New pattern from WAIT_SEL with reserved size code, then deconv.
        do_load(2'd3, 1024, "load3");
        check("load3_size", 64'(size_r), 64'd0);
        do_sel(1'b1, 4'd5, 4'd9);
        cur.delete();
        for (int k = 0; k < 144; k++) begin
            w = 20'(k * 24593 + 5);
            cur.push_back('{w, 0, w});
        end
        run_results("deconv144", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
